// File: rtl/mio_bus_responder.sv
// mio_bus_responder
//   Memory/IO responder on the far side of the CPU's MIO bus. Accepts one
//   read or write request, inserts a programmable number of wait states,
//   then returns a one-cycle mio_ready pulse with registered read data.
//
//   Address map (byte addresses):
//     0x0xxxxxxx  word RAM, index addr[RAM_AW+1:2] (upper bits alias)
//     0xE0000000  LED register, R/W (low 16 bits)
//     0xF0000000  switches, read-only
//     0xF0000004  free-running cycle counter, read-only
//   Unmapped, misaligned or read+write requests respond with rdata=0 and
//   set the sticky bus_err flag.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   mem_r      read request
//   mem_w      write request
//   cpu_mio    request qualifier
//   addr       byte address
//   wdata      write data
//   rdata      read data, valid while mio_ready is high, held until next response
//   mio_ready  one-cycle completion pulse
//   led_out    LED register contents
//   sw_in      switch inputs, sampled when the response is formed
//   bus_err    sticky error flag, cleared only by reset
module mio_bus_responder #(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 2,
    parameter int IO_WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        cpu_mio,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    output logic [15:0] led_out,
    input  logic [15:0] sw_in,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [2:0] {T_RAM, T_LED, T_SW, T_CNT, T_ERR} tgt_t;

    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    state_t            state, state_nx;
    logic [3:0]        wcnt, wcnt_nx;
    logic              accept, enter_resp;
    tgt_t              dec_tgt, req_tgt, ent_tgt;
    logic [3:0]        dec_wait;
    logic              req_wr;
    logic [RAM_AW-1:0] req_idx, ent_idx;
    logic [31:0]       req_wdata;
    logic [31:0]       cycle_cnt;
    logic [31:0]       rd_val;
    logic [31:0]       mem [2**RAM_AW];

    // Target decode of the live bus; only meaningful when a request is accepted.
    always_comb begin
        dec_tgt = T_ERR;
        if (mem_r & mem_w)
            dec_tgt = T_ERR;
        else if (addr[1:0] != 2'b00)
            dec_tgt = T_ERR;
        else if (addr[31:28] == 4'h0)
            dec_tgt = T_RAM;
        else if (addr == 32'hE000_0000)
            dec_tgt = T_LED;
        else if (addr == 32'hF000_0000)
            dec_tgt = T_SW;
        else if (addr == 32'hF000_0004)
            dec_tgt = T_CNT;
        dec_wait = (dec_tgt == T_RAM) ? RAM_WAIT_C : IO_WAIT_C;
    end

    always_comb begin
        accept     = cpu_mio & (mem_r | mem_w);
        state_nx   = state;
        wcnt_nx    = wcnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_wait == 4'd0) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        // WAIT lasts dec_wait cycles: count dec_wait-1 down to 0.
                        state_nx = WAIT;
                        wcnt_nx  = dec_wait - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Zero-wait accesses enter RESP straight from IDLE, before the request
    // registers hold the access, so the response mux takes the live decode.
    always_comb begin
        ent_tgt = (state == IDLE) ? dec_tgt : req_tgt;
        ent_idx = (state == IDLE) ? addr[RAM_AW+1:2] : req_idx;
        case (ent_tgt)
            T_RAM:   rd_val = mem[ent_idx];
            T_LED:   rd_val = {16'h0, led_out};
            T_SW:    rd_val = {16'h0, sw_in};
            // Counter value as seen during the RESP cycle itself.
            T_CNT:   rd_val = cycle_cnt + 32'd1;
            default: rd_val = '0;
        endcase
    end

    always_comb mio_ready = (state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            req_tgt   <= T_ERR;
            req_wr    <= 1'b0;
            req_idx   <= '0;
            req_wdata <= '0;
            cycle_cnt <= '0;
            rdata     <= '0;
            led_out   <= '0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            wcnt      <= wcnt_nx;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state == IDLE && accept) begin
                req_tgt   <= dec_tgt;
                req_wr    <= mem_w;
                req_idx   <= addr[RAM_AW+1:2];
                req_wdata <= wdata;
            end
            if (enter_resp) begin
                rdata <= rd_val;
                if (ent_tgt == T_ERR)
                    bus_err <= 1'b1;
            end
            if (state == RESP && req_wr && req_tgt == T_LED)
                led_out <= req_wdata[15:0];
        end
    end

    // RAM is not reset; the reset guard keeps a write from committing on an
    // edge where reset is already asserted.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && req_wr && req_tgt == T_RAM)
            mem[req_idx] <= req_wdata;
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
module tb_mio_bus_responder;
    localparam int AW = 10;
    localparam int RW = 2;
    localparam int IW = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_r = 1'b0, mem_w = 1'b0, cpu_mio = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        mio_ready;
    logic [15:0] led_out;
    logic [15:0] sw_in = '0;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    int cyc_tb = 0;
    int last_ready_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_tb++;

    mio_bus_responder #(.RAM_AW(AW), .RAM_WAIT(RW), .IO_WAIT(IW)) dut (
        .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .cpu_mio(cpu_mio),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
        .led_out(led_out), .sw_in(sw_in), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // 0=RAM 1=LED 2=SW 3=CNT 4=error
    function automatic int tgt_of(logic r, logic w, logic [31:0] a);
        if (r && w) return 4;
        if (a % 4 != 0) return 4;
        if (a < 32'h1000_0000) return 0;
        if (a == 32'hE000_0000) return 1;
        if (a == 32'hF000_0000) return 2;
        if (a == 32'hF000_0004) return 3;
        return 4;
    endfunction

    function automatic int wait_of(int t);
        return (t == 0) ? RW : IW;
    endfunction

    // ---------------- behavioural model ----------------
    // Works in absolute cycle numbers: a request seen in the cycle numbered C
    // is answered in cycle C+1+wait; its write lands when that cycle ends.
    logic [31:0] mref [int];
    logic [31:0] m_cyc, m_resp_at, m_a, m_d, exp_rdata;
    logic        m_busy, m_r, m_w, exp_ready, exp_err;
    logic [15:0] exp_led;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_busy = 0; exp_ready = 0; exp_rdata = 0; exp_led = 0; exp_err = 0;
        end else begin
            bit cap;
            int t;
            int idx;
            cap = !m_busy && cpu_mio && (mem_r || mem_w);
            m_cyc = m_cyc + 1;
            if (exp_ready) begin
                t = tgt_of(m_r, m_w, m_a);
                idx = int'((m_a / 4) % (2 ** AW));
                if (m_w && t == 0) mref[idx] = m_d;
                if (m_w && t == 1) exp_led = m_d[15:0];
                exp_ready = 0;
                m_busy = 0;
            end
            if (cap) begin
                m_r = mem_r; m_w = mem_w; m_a = addr; m_d = wdata;
                m_busy = 1;
                m_resp_at = m_cyc + 32'(wait_of(tgt_of(mem_r, mem_w, addr)));
            end
            if (m_busy && !exp_ready && m_cyc == m_resp_at) begin
                t = tgt_of(m_r, m_w, m_a);
                idx = int'((m_a / 4) % (2 ** AW));
                exp_ready = 1;
                case (t)
                    0:       exp_rdata = mref.exists(idx) ? mref[idx] : 32'h0;
                    1:       exp_rdata = {16'h0, exp_led};
                    2:       exp_rdata = {16'h0, sw_in};
                    3:       exp_rdata = m_cyc;
                    default: begin exp_rdata = 0; exp_err = 1; end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("mio_ready", 32'(mio_ready), 32'(exp_ready));
            check("rdata", rdata, exp_rdata);
            check("led_out", 32'(led_out), 32'(exp_led));
            check("bus_err", 32'(bus_err), 32'(exp_err));
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; holds the request until mio_ready,
    // then releases the bus just after the edge that ends RESP.
    task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
        mem_r = r; mem_w = w; cpu_mio = 1'b1; addr = a; wdata = d;
        lat = 0;
        forever begin
            @(negedge clk);
            if (mio_ready) break;
            lat++;
            if (lat > 40) begin
                total++; bad++;
                $display("FAIL ready_timeout: no mio_ready after %0d cycles, addr %h", lat, a);
                break;
            end
        end
        rd = rdata;
        last_ready_cyc = cyc_tb;
        @(posedge clk); #1;
        mem_r = 1'b0; mem_w = 1'b0; cpu_mio = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, rd1, rd2, a;
        int lat, c1, c2, kind, t;
        logic r, w;

        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(mio_ready), 32'h0);
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_err", 32'(bus_err), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // preload RAM words 0..15 and word 0x80
        for (int i = 0; i < 16; i++) txn(0, 1, 32'(i * 4), $urandom, rd, lat);
        txn(0, 1, 32'h0000_0010, 32'h1234_5678, rd, lat);
        check("ram_write_latency", 32'(lat), 32'd3);
        txn(0, 1, 32'h0000_0080, 32'hCAFE_0080, rd, lat);

        // RAM read: ready in cycle 3, one cycle wide
        txn(1, 0, 32'h0000_0010, 32'h0, rd, lat);
        check("ram_read_latency", 32'(lat), 32'd3);
        check("ram_read_data", rd, 32'h1234_5678);
        @(negedge clk);
        check("ready_one_cycle", 32'(mio_ready), 32'h0);
        @(posedge clk); #1;

        // write then back-to-back read
        txn(0, 1, 32'h0000_0040, 32'hA5A5_1234, rd, lat);
        txn(1, 0, 32'h0000_0040, 32'h0, rd, lat);
        check("b2b_read", rd, 32'hA5A5_1234);

        // LED write and switch read
        txn(0, 1, 32'hE000_0000, 32'h0000_BEEF, rd, lat);
        check("led_latency", 32'(lat), 32'd1);
        check("led_after_write", 32'(led_out), 32'h0000_BEEF);
        sw_in = 16'h00F0;
        txn(1, 0, 32'hF000_0000, 32'h0, rd, lat);
        check("sw_read", rd, 32'h0000_00F0);

        // error accesses
        txn(1, 0, 32'h3000_0000, 32'h0, rd, lat);
        check("unmapped_rdata", rd, 32'h0);
        check("unmapped_err", 32'(bus_err), 32'h1);
        txn(1, 0, 32'h0000_0002, 32'h0, rd, lat);
        check("misaligned_rdata", rd, 32'h0);
        check("misaligned_latency", 32'(lat), 32'd1);
        txn(1, 1, 32'h0000_0040, 32'h5555_5555, rd, lat);
        check("rw_both_rdata", rd, 32'h0);
        check("err_sticky", 32'(bus_err), 32'h1);
        txn(1, 0, 32'h0000_0040, 32'h0, rd, lat);
        check("ram_untouched_by_err", rd, 32'hA5A5_1234);
        check("led_untouched_by_err", 32'(led_out), 32'h0000_BEEF);

        // reset during WAIT of a RAM write
        mem_w = 1'b1; cpu_mio = 1'b1; addr = 32'h0000_0080; wdata = 32'h1111_1111;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        mem_w = 1'b0; cpu_mio = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ready_in_reset", 32'(mio_ready), 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_led", 32'(led_out), 32'h0);
        check("reset_err", 32'(bus_err), 32'h0);
        @(posedge clk); #1;
        txn(1, 0, 32'h0000_0080, 32'h0, rd, lat);
        check("cancelled_write", rd, 32'hCAFE_0080);

        // cycle counter distance
        txn(1, 0, 32'hF000_0004, 32'h0, rd1, lat);
        c1 = last_ready_cyc;
        repeat (5) @(posedge clk);
        #1;
        txn(1, 0, 32'hF000_0004, 32'h0, rd2, lat);
        c2 = last_ready_cyc;
        check("cnt_vs_cycles", rd2 - rd1, 32'(c2 - c1));
        check("cnt_distance", rd2 - rd1, 32'd7);

        // requests without cpu_mio are ignored
        for (int i = 0; i < 6; i++) begin
            mem_r = i[0]; cpu_mio = 1'b0; addr = 32'hF000_0000;
            @(negedge clk);
            check("no_ready_without_mio", 32'(mio_ready), 32'h0);
            @(posedge clk); #1;
        end
        mem_r = 1'b0;

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            r = 1'b0; w = 1'b0;
            if ($urandom_range(0, 1) == 0) r = 1'b1; else w = 1'b1;
            case (kind)
                0, 1, 2, 3: a = ($urandom & 32'h0FFF_F000) | 32'($urandom_range(0, 15) * 4);
                4:          a = 32'hE000_0000;
                5:          a = 32'hF000_0000;
                6:          a = 32'hF000_0004;
                7:          a = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFC);
                8:          a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                default: begin a = 32'($urandom_range(0, 15) * 4); r = 1'b1; w = 1'b1; end
            endcase
            t = tgt_of(r, w, a);
            txn(r, w, a, $urandom, rd, lat);
            check("rand_latency", 32'(lat), 32'(1 + wait_of(t)));
            repeat ($urandom_range(0, 3)) begin
                mem_r = 1'($urandom); mem_w = 1'($urandom); cpu_mio = 1'b0;
                addr = $urandom; sw_in = 16'($urandom);
                @(posedge clk); #1;
            end
            mem_r = 1'b0; mem_w = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO responder on the far side of the multicycle CPU's MIO bus.
- Captures one read or write request from the CPU controller, inserts a programmable number of wait states, then returns a one-cycle ready pulse with read data.
- Decodes the address into three targets: word RAM, an LED register and a read-only IO block (switches plus a free-running cycle counter).
- Unmapped or malformed accesses are flagged.

Parameters:
RAM_AW, 10, RAM word-address width (depth = 2^RAM_AW words of 32 bits)
RAM_WAIT, 2, wait cycles inserted for RAM accesses (0..15)
IO_WAIT, 0, wait cycles inserted for LED/IO/error accesses (0..15)

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
mem_r  input  1  read request from CPU controller
mem_w  input  1  write request from CPU controller
cpu_mio  input  1  request qualifier; a request is accepted only when high
addr  input  32  byte address of access
wdata  input  32  write data
rdata  output  32  read data, valid in the mio_ready cycle
mio_ready  output  1  one-cycle completion pulse
led_out  output  16  LED register contents
sw_in  input  16  switch inputs (sampled at response)
bus_err  output  1  sticky error flag

Behaviour:
- Reset (asynchronous, active-high) forces:
  - FSM to IDLE, mio_ready=0, rdata=0, led_out=0, bus_err=0, cycle counter=0.
  - RAM contents are not reset.
  - No write in flight commits.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps from 0xFFFFFFFF to 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if cpu_mio & (mem_r | mem_w) at a rising edge, latch addr, wdata, read/write and the decoded target. Go to WAIT if the selected wait count is >0, else to RESP.
  - WAIT: down-counter loaded with RAM_WAIT or IO_WAIT. Go to RESP when it reaches 0. All bus inputs are ignored here; the CPU may drop cpu_mio during its wait states.
  - RESP: mio_ready=1 for exactly this cycle. Read data is registered on entry and holds until the next response. Return to IDLE.
  - A request may be accepted in the cycle immediately after RESP (back-to-back, no turnaround).
- Latency: the request is visible in cycle 0; mio_ready is asserted in cycle 1+WAIT.
- Writes commit on the edge that ends the RESP cycle. Reset asserted during WAIT or RESP cancels the write.
- Address map (latched address):
  - addr[31:28]==0x0: RAM, word index addr[RAM_AW+1:2]. Upper index bits beyond RAM_AW are ignored (aliasing).
  - 0xE0000000: LED register, R/W. Writes take wdata[15:0]; reads return {16'h0, led_out}.
  - 0xF0000000: switches, read-only. Returns {16'h0, sw_in}; writes are ignored without error.
  - 0xF0000004: cycle counter, read-only. Returns the value at RESP entry; writes are ignored.
  - Anything else is unmapped.
- Error cases: unmapped address, addr[1:0]!=0, or mem_r & mem_w both high at capture.
  - No storage is modified.
  - The access uses IO_WAIT.
  - rdata=0, mio_ready still pulses (the CPU never hangs).
  - bus_err is set and stays set until reset.
- mem_r/mem_w with cpu_mio=0 in IDLE: ignored; no response is generated.

Test Plan:
- Reset, then read RAM word 0x00000010 with RAM_WAIT=2, mem_r held -> mio_ready=1 exactly in cycle 3, one cycle wide; rdata equals the preloaded word; then IDLE.
- Write 0xA5A5_1234 to 0x00000040, then read it back immediately on the next cycle after ready -> write commits at end of RESP; the back-to-back read returns 0xA5A51234 with no turnaround.
- Write 0x0000_BEEF to 0xE0000000 with IO_WAIT=0 -> ready in cycle 1; led_out=0xBEEF after that edge. Read 0xF0000000 with sw_in=0x00F0 -> rdata=0x000000F0.
- Read 0x30000000, then misaligned read 0x00000002, then mem_r & mem_w together -> each gets a ready pulse with rdata=0; no RAM or LED change; bus_err=1 after the first and stays 1.
- Assert reset during WAIT of a write of 0x11111111 to 0x00000080 -> mio_ready never pulses; word 0x80 keeps its old value; led_out=0, bus_err=0.
- Two reads of 0xF0000004 separated by 5 idle cycles -> rdata difference equals the cycle distance between the two RESP entries. Also toggle mem_r with cpu_mio=0 -> no mio_ready.
